demux_4_buf: RTL and testbench
==============================

Name: demux_4_buf

Overview:
- Registered 1-to-4 demultiplexer with a valid/ready handshake on the input and on each output.
- Routes one N-bit word per accepted transfer to the output selected by a 2-bit select.
- Holds the word in a one-entry buffer per output until the consumer takes it.
- Counterpart of the 4-input mux in the ALU datapath: fans a single result bus out to four consumers (e.g. register-file write ports or next-stage units) that may stall independently.

Parameters:
N, 64, data width of the input word and of each output word.

Ports:
i_clk     input   1   clock; all state updates on the rising edge.
i_reset   input   1   synchronous, active-high reset.
i_in      input   N   input data word.
i_s       input   2   destination select; 00 -> out0, 01 -> out1, 10 -> out2, 11 -> out3.
i_valid   input   1   input word and select are valid.
o_ready   output  1   block accepts the input word this cycle.
o_out0    output  N   buffered word for consumer 0.
o_out1    output  N   buffered word for consumer 1.
o_out2    output  N   buffered word for consumer 2.
o_out3    output  N   buffered word for consumer 3.
o_valid   output  4   bit k set: o_outk holds an untaken word.
i_ready   input   4   bit k set: consumer k takes o_outk this cycle.

Behaviour:
- State per output k: data register D[k] (N bits, drives o_outk) and full flag F[k] (drives o_valid[k]).
- Reset (i_reset=1 at the clock edge):
  - All F cleared, all D cleared to 0.
  - o_ready is 0 while i_reset is high.
  - Reset mid-operation discards every buffered word; no output transfer is reported after the reset edge.
- o_ready is combinational: o_ready = !i_reset && (!F[i_s] || i_ready[i_s]).
  - It depends only on the selected output; a full non-selected output never blocks the input (no head-of-line blocking).
- Input transfer: i_valid && o_ready at the rising edge.
  - Effect: D[i_s] <= i_in, F[i_s] <= 1.
  - Latency: the word appears on o_out[i_s] with o_valid set in the cycle after acceptance.
- Output transfer on k: F[k] && i_ready[k] at the rising edge; F[k] clears unless output k is reloaded in the same cycle.
- Simultaneous drain and load on the same k:
  - F[k] stays 1 and D[k] takes the new word, giving full throughput of one word per cycle per output.
- Drains on different outputs in the same cycle are independent; up to 4 output transfers per cycle.
- After a drain, D[k] keeps its last value; consumers ignore o_outk while o_valid[k]=0.
- Output stability: while F[k] && !i_ready[k], D[k] and F[k] are unchanged.
- Input-side rule: once the source asserts i_valid, it holds i_in and i_s stable until o_ready.
  - The bench checks this rule with an assertion.
  - The block does not depend on it for correctness; it just samples each edge.
- i_ready[k] while F[k]=0 has no effect.
- i_valid=0: no state change on the input side, regardless of o_ready.
- No internal counters or FSM beyond the four F flags; the per-output state is EMPTY (F=0) / FULL (F=1).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on load+drain, or on stall.
- Width rules: no arithmetic; data passes bit-exact for any N >= 1.

Test Plan:
- Reset/idle: hold i_reset 3 cycles with i_valid=1, i_s=01 -> o_ready=0, o_valid=0000, all o_out=0; release with i_ready=1111 -> o_ready=1 the same cycle.
- Routing (N=64):
  - Stimulus: send 0x1111 to s=00, 0x2222 to s=01, 0x3333 to s=10, 0x4444 to s=11 on consecutive cycles, all i_ready=0.
  - Required: o_valid goes 0001, 0011, 0111, 1111, one cycle after each accept; each o_outk holds its word; o_ready then 0 for every select.
- Backpressure isolation:
  - Stimulus: output 2 full with i_ready[2]=0; send 0xAAAA with s=10, then switch to s=00 with 0xBBBB.
  - Required: for s=10, o_ready=0 and o_out2 stays 0x3333; for s=00, accepted next edge and o_out0=0xBBBB.
- Streaming: i_ready[1]=1, i_valid=1, s=01, words 1..8 on back-to-back cycles -> o_ready=1 every cycle, o_out1 shows 1..8 one cycle delayed, o_valid[1] never drops during the burst.
- Parallel drain: all four full, set i_ready=1111 for one cycle with i_valid=0 -> o_valid=0000 next cycle; o_out0..3 retain their last words.
- Reset mid-stream: during the streaming test, assert i_reset for 1 cycle -> next cycle o_valid=0000 and o_out*=0; the word presented in the reset cycle is not delivered.

Source files
------------

// File: rtl/demux_4_buf_if.sv
// Handshake bundle for demux_4_buf: one valid/ready input lane and four
// buffered output lanes, each with its own valid/ready pair.
interface demux_4_buf_if #(
  parameter int N = 64
);
  logic [N-1:0] i_in;
  logic [1:0]   i_s;
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] o_out0;
  logic [N-1:0] o_out1;
  logic [N-1:0] o_out2;
  logic [N-1:0] o_out3;
  logic [3:0]   o_valid;
  logic [3:0]   i_ready;

  modport master (
    output i_in, i_s, i_valid, i_ready,
    input  o_ready, o_out0, o_out1, o_out2, o_out3, o_valid
  );

  modport slave (
    input  i_in, i_s, i_valid, i_ready,
    output o_ready, o_out0, o_out1, o_out2, o_out3, o_valid
  );
endinterface

// File: rtl/demux_4_buf.sv
// Registered 1-to-4 demultiplexer with a one-entry buffer per output, so a
// stalled consumer never blocks traffic headed to the other three.
//
// state (per output) | meaning
// EMPTY (full_q=0)   | no untaken word; o_outk holds the last drained value
// FULL  (full_q=1)   | o_outk holds a word the consumer has not taken yet
module demux_4_buf #(
  parameter int N = 64
) (
  input logic           i_clk,
  input logic           i_reset,
  demux_4_buf_if.slave  bus
);

  logic [N-1:0] data_q [4];
  logic [N-1:0] data_d [4];
  logic [3:0]   full_q;
  logic [3:0]   full_d;
  logic [3:0]   load;
  logic [3:0]   drain;
  logic         ready;

  // Only the selected lane gates acceptance; a slot draining this cycle can
  // be reloaded on the same edge.
  always_comb begin
    ready = !i_reset && (!full_q[bus.i_s] || bus.i_ready[bus.i_s]);
    load  = 4'b0000;
    if (bus.i_valid && ready) begin
      load[bus.i_s] = 1'b1;
    end
    drain  = full_q & bus.i_ready;
    full_d = (full_q & ~drain) | load;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = load[k] ? bus.i_in : data_q[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      full_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = full_q;
  assign bus.o_out0  = data_q[0];
  assign bus.o_out1  = data_q[1];
  assign bus.o_out2  = data_q[2];
  assign bus.o_out3  = data_q[3];

endmodule

// File: tb/tb_demux_4_buf.sv
// Directed bench for demux_4_buf: a vector table for reset, routing,
// backpressure and drain, plus hand-written streaming and mid-stream reset.
module tb_demux_4_buf;

  localparam int N = 64;

  typedef struct {
    logic         rst;
    logic         vld;
    logic [1:0]   s;
    logic [N-1:0] din;
    logic [3:0]   rdy;
    logic         rule;
    logic         xr;
    logic [3:0]   xv;
    logic [N-1:0] x0;
    logic [N-1:0] x1;
    logic [N-1:0] x2;
    logic [N-1:0] x3;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rule_en = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  demux_4_buf_if #(.N(N)) bus ();

  demux_4_buf #(.N(N)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Source must hold word and select while stalled (waived for the
  // backpressure-isolation vectors, which switch select on purpose).
  a_src_hold : assert property (@(posedge clk) disable iff (rst || !rule_en)
    (bus.i_valid && !bus.o_ready) |=> (bus.i_valid && $stable(bus.i_in) && $stable(bus.i_s)));

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [1:0] s, input logic [N-1:0] d,
                     input logic [3:0] rd, input logic ru, input logic xr, input logic [3:0] xv,
                     input logic [N-1:0] x0, input logic [N-1:0] x1,
                     input logic [N-1:0] x2, input logic [N-1:0] x3);
    vec_t t;
    t.rst = r; t.vld = v; t.s = s; t.din = d; t.rdy = rd; t.rule = ru;
    t.xr = xr; t.xv = xv; t.x0 = x0; t.x1 = x1; t.x2 = x2; t.x3 = x3;
    vecs.push_back(t);
  endtask

  // Drive one cycle: o_ready checked before the edge, registered outputs after.
  task automatic apply(input vec_t t, input string tag);
    rule_en         = t.rule;
    rst             = t.rst;
    bus.i_valid     = t.vld;
    bus.i_s         = t.s;
    bus.i_in        = t.din;
    bus.i_ready     = t.rdy;
    #1;
    chk({tag, " o_ready"}, {{(N-1){1'b0}}, bus.o_ready}, {{(N-1){1'b0}}, t.xr});
    @(posedge clk);
    #1;
    chk({tag, " o_valid"}, {{(N-4){1'b0}}, bus.o_valid}, {{(N-4){1'b0}}, t.xv});
    chk({tag, " o_out0"}, bus.o_out0, t.x0);
    chk({tag, " o_out1"}, bus.o_out1, t.x1);
    chk({tag, " o_out2"}, bus.o_out2, t.x2);
    chk({tag, " o_out3"}, bus.o_out3, t.x3);
  endtask

  initial begin
    vec_t t;
    bus.i_valid = 1'b0;
    bus.i_s     = 2'b00;
    bus.i_in    = '0;
    bus.i_ready = 4'b0000;

    //  rst v  s      din     rdy      ru xr  xv       out0    out1    out2    out3
    for (int i = 0; i < 3; i++)
      add(1, 1, 2'd1, 64'hDEAD, 4'b0000, 1, 0, 4'b0000, 0,      0,      0,      0);
    add(0, 1, 2'd1, 64'h5555, 4'b1111, 1, 1, 4'b0010, 0,      64'h5555, 0,    0);
    add(0, 0, 2'd0, 64'h0,    4'b1111, 1, 1, 4'b0000, 0,      64'h5555, 0,    0);
    // routing
    add(0, 1, 2'd0, 64'h1111, 4'b0000, 1, 1, 4'b0001, 64'h1111, 64'h5555, 0, 0);
    add(0, 1, 2'd1, 64'h2222, 4'b0000, 1, 1, 4'b0011, 64'h1111, 64'h2222, 0, 0);
    add(0, 1, 2'd2, 64'h3333, 4'b0000, 1, 1, 4'b0111, 64'h1111, 64'h2222, 64'h3333, 0);
    add(0, 1, 2'd3, 64'h4444, 4'b0000, 1, 1, 4'b1111, 64'h1111, 64'h2222, 64'h3333, 64'h4444);
    for (int s = 0; s < 4; s++)
      add(0, 0, 2'(s), 64'h0,  4'b0000, 1, 0, 4'b1111, 64'h1111, 64'h2222, 64'h3333, 64'h4444);
    // backpressure isolation: out2 stalled, out0 drains, then s=00 accepted
    add(0, 1, 2'd2, 64'hAAAA, 4'b0001, 0, 0, 4'b1110, 64'h1111, 64'h2222, 64'h3333, 64'h4444);
    add(0, 1, 2'd0, 64'hBBBB, 4'b0000, 0, 1, 4'b1111, 64'hBBBB, 64'h2222, 64'h3333, 64'h4444);
    // parallel drain, then ready on empty outputs has no effect
    add(0, 0, 2'd0, 64'h0,    4'b1111, 1, 1, 4'b0000, 64'hBBBB, 64'h2222, 64'h3333, 64'h4444);
    add(0, 0, 2'd0, 64'h0,    4'b1111, 1, 1, 4'b0000, 64'hBBBB, 64'h2222, 64'h3333, 64'h4444);
    add(0, 1, 2'd0, 64'h0,    4'b0000, 1, 1, 4'b0001, 64'h0,    64'h2222, 64'h3333, 64'h4444);
    add(0, 0, 2'd0, 64'h0,    4'b0001, 1, 1, 4'b0000, 64'h0,    64'h2222, 64'h3333, 64'h4444);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // streaming on out1 with load+drain every cycle
    for (int w = 1; w <= 8; w++) begin
      t = '{rst:0, vld:1, s:2'd1, din:64'(w), rdy:4'b0010, rule:1, xr:1, xv:4'b0010,
            x0:64'h0, x1:64'(w), x2:64'h3333, x3:64'h4444};
      apply(t, $sformatf("stream%0d", w));
    end
    t = '{rst:0, vld:0, s:2'd1, din:64'h0, rdy:4'b0010, rule:1, xr:1, xv:4'b0000,
          x0:64'h0, x1:64'h8, x2:64'h3333, x3:64'h4444};
    apply(t, "stream_end");

    // reset mid-stream: word presented during reset is dropped
    t = '{rst:0, vld:1, s:2'd1, din:64'h11, rdy:4'b0000, rule:1, xr:1, xv:4'b0010,
          x0:64'h0, x1:64'h11, x2:64'h3333, x3:64'h4444};
    apply(t, "mid_pre");
    t = '{rst:1, vld:1, s:2'd1, din:64'h12, rdy:4'b0000, rule:1, xr:0, xv:4'b0000,
          x0:64'h0, x1:64'h0, x2:64'h0, x3:64'h0};
    apply(t, "mid_rst");
    t = '{rst:0, vld:0, s:2'd1, din:64'h12, rdy:4'b0010, rule:1, xr:1, xv:4'b0000,
          x0:64'h0, x1:64'h0, x2:64'h0, x3:64'h0};
    apply(t, "mid_post");
    t = '{rst:0, vld:1, s:2'd1, din:64'h13, rdy:4'b0000, rule:1, xr:1, xv:4'b0010,
          x0:64'h0, x1:64'h13, x2:64'h0, x3:64'h0};
    apply(t, "mid_resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
